// File: rtl/sgdmac_rd_sched.sv
// Read-port scheduler: arbitrates N_REQ requesters onto one AXI AR channel and routes R beats back by ID.
// Optional macro SGDMAC_RD_SCHED_STRICT_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module sgdmac_rd_sched #(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned MAX_OUTS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_arvalid_i,
    output logic [N_REQ-1:0]    req_arready_o,
    input  logic [N_REQ*32-1:0] req_araddr_i,
    input  logic [N_REQ*4-1:0]  req_arlen_i,
    input  logic [N_REQ*3-1:0]  req_arsize_i,
    input  logic [N_REQ*2-1:0]  req_arburst_i,
    output logic [ID_W-1:0]     arid_o,
    output logic [31:0]         araddr_o,
    output logic [3:0]          arlen_o,
    output logic [2:0]          arsize_o,
    output logic [1:0]          arburst_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [ID_W-1:0]     rid_i,
    input  logic                rlast_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    output logic [N_REQ-1:0]    req_rvalid_o,
    input  logic [N_REQ-1:0]    req_rready_i,
    output logic                id_err_o
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTS + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    grant_idx;
    logic             grant_found;
    logic             accept;
    logic             rid_hit;
    logic             rid_rready;
    logic             last_hs;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] cnt_inc;
    logic [N_REQ-1:0] cnt_dec;
    logic [CW-1:0]    cnt [N_REQ];

    // A requester may compete only while it has outstanding-burst credit left
    always_comb begin
        elig = '0;
        for (int k = 0; k < N_REQ; k++) begin
            elig[k] = req_arvalid_i[k] && (cnt[k] < CW'(MAX_OUTS));
        end
    end

`ifdef SGDMAC_RD_SCHED_STRICT_PRIO_EN
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_found && elig[i]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] scan;

    // Search starts at rr_ptr and wraps, so the last winner has lowest priority
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan = IW'((int'(rr_ptr) + i) % int'(N_REQ));
            if (!grant_found && elig[scan]) begin
                grant_found = 1'b1;
                grant_idx   = scan;
            end
        end
    end
`endif

    assign accept = (state == IDLE) && grant_found;

    always_comb begin
        req_arready_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_arready_o[k] = accept && (grant_idx == IW'(k));
        end
    end

    // R routing: unknown IDs are drained so the bus never stalls on them
    always_comb begin
        rid_hit      = 1'b0;
        rid_rready   = 1'b0;
        req_rvalid_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (rid_i == ID_W'(k)) begin
                rid_hit         = 1'b1;
                rid_rready      = req_rready_i[k];
                req_rvalid_o[k] = rvalid_i;
            end
        end
    end

    assign rready_o = rid_hit ? rid_rready : 1'b1;
    assign last_hs  = rvalid_i && rready_o && rlast_i;

    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cnt_inc[k] = accept && (grant_idx == IW'(k));
            cnt_dec[k] = last_hs && (rid_i == ID_W'(k)) && (cnt[k] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_REQ; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (cnt_inc[k] && !cnt_dec[k]) begin
                    cnt[k] <= cnt[k] + 1'b1;
                end else if (cnt_dec[k] && !cnt_inc[k]) begin
                    cnt[k] <= cnt[k] - 1'b1;
                end
            end
        end
    end

    // Issue FSM: payload captured on accept and held until the AR handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            arvalid_o <= 1'b0;
            arid_o    <= '0;
            araddr_o  <= '0;
            arlen_o   <= '0;
            arsize_o  <= '0;
            arburst_o <= '0;
            id_err_o  <= 1'b0;
        end else begin
            id_err_o <= rvalid_i && !rid_hit;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        for (int k = 0; k < N_REQ; k++) begin
                            if (grant_idx == IW'(k)) begin
                                araddr_o  <= req_araddr_i[32*k +: 32];
                                arlen_o   <= req_arlen_i[4*k +: 4];
                                arsize_o  <= req_arsize_i[3*k +: 3];
                                arburst_o <= req_arburst_i[2*k +: 2];
                            end
                        end
                        arid_o    <= ID_W'(grant_idx);
                        rr_ptr    <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        arvalid_o <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sgdmac_rd_sched.sv
// Bench for sgdmac_rd_sched: cycle model plus AR payload scoreboard, directed scenarios then random traffic.
module tb_sgdmac_rd_sched;

    localparam int N_REQ    = 2;
    localparam int ID_W     = 4;
    localparam int MAX_OUTS = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req_arvalid;
    logic [N_REQ-1:0]    req_arready_o;
    logic [N_REQ*32-1:0] req_araddr;
    logic [N_REQ*4-1:0]  req_arlen;
    logic [N_REQ*3-1:0]  req_arsize;
    logic [N_REQ*2-1:0]  req_arburst;
    logic [ID_W-1:0]     arid_o;
    logic [31:0]         araddr_o;
    logic [3:0]          arlen_o;
    logic [2:0]          arsize_o;
    logic [1:0]          arburst_o;
    logic                arvalid_o;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic                rlast;
    logic                rvalid;
    logic                rready_o;
    logic [N_REQ-1:0]    req_rvalid_o;
    logic [N_REQ-1:0]    req_rready;
    logic                id_err_o;

    sgdmac_rd_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .MAX_OUTS(MAX_OUTS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_arvalid_i(req_arvalid), .req_arready_o(req_arready_o),
        .req_araddr_i(req_araddr), .req_arlen_i(req_arlen),
        .req_arsize_i(req_arsize), .req_arburst_i(req_arburst),
        .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
        .arsize_o(arsize_o), .arburst_o(arburst_o),
        .arvalid_o(arvalid_o), .arready_i(arready),
        .rid_i(rid), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready_o),
        .req_rvalid_o(req_rvalid_o), .req_rready_i(req_rready),
        .id_err_o(id_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    ar_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    bit  mon_en = 1'b0;
    bit  m_busy;
    int  m_ptr;
    int  m_cnt [N_REQ];
    bit  m_err;
    int  mg;
    int  mk;
    bit  m_in_range;
    bit  m_dec;
    logic             m_rr;
    logic [N_REQ-1:0] m_rdy;
    logic [N_REQ-1:0] m_rv;
    ar_t              m_ar;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [3:0] l,
                           input logic [2:0] s, input logic [1:0] b);
        req_araddr[32*k +: 32] = a;
        req_arlen[4*k +: 4]    = l;
        req_arsize[3*k +: 3]   = s;
        req_arburst[2*k +: 2]  = b;
    endtask

    task automatic rbeat(input int id, input bit last, input logic [N_REQ-1:0] rr);
        rid        = ID_W'(id);
        rlast      = last;
        rvalid     = 1'b1;
        req_rready = rr;
        tick();
        rvalid     = 1'b0;
        rlast      = 1'b0;
    endtask

    task automatic drain();
        req_arvalid = '0;
        arready     = 1'b1;
        tick();
        tick();
        for (int i = 0; i < MAX_OUTS + 1; i++) begin
            rbeat(0, 1'b1, 2'b11);
            rbeat(1, 1'b1, 2'b11);
        end
    endtask

    // Cycle model: predicts grants, AR payloads and R routing from the inputs held this cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_err  = 1'b0;
            for (int k = 0; k < N_REQ; k++) m_cnt[k] = 0;
            exp_q.delete();
        end else if (mon_en) begin
            mg = -1;
            for (int i = 0; i < N_REQ; i++) begin
`ifdef SGDMAC_RD_SCHED_STRICT_PRIO_EN
                mk = i;
`else
                mk = (m_ptr + i) % N_REQ;
`endif
                if (mg < 0 && req_arvalid[mk] && m_cnt[mk] < MAX_OUTS) mg = mk;
            end
            m_rdy = '0;
            if (!m_busy && mg >= 0) m_rdy[mg] = 1'b1;
            check("arready", 64'(req_arready_o), 64'(m_rdy));
            check("arvalid", 64'(arvalid_o), 64'(m_busy));
            if (m_busy) begin
                if (exp_q.size() == 0) begin
                    check("ar_unexpected", 64'(1), 64'(0));
                end else begin
                    check("ar_payload", 64'({arid_o, araddr_o, arlen_o, arsize_o, arburst_o}),
                          64'(exp_q[0]));
                    if (arready) void'(exp_q.pop_front());
                end
            end
            m_in_range = (rid < N_REQ);
            m_rr = m_in_range ? req_rready[rid] : 1'b1;
            m_rv = '0;
            if (m_in_range && rvalid) m_rv[rid] = 1'b1;
            check("rready", 64'(rready_o), 64'(m_rr));
            check("r_route", 64'(req_rvalid_o), 64'(m_rv));
            check("id_err", 64'(id_err_o), 64'(m_err));
            m_err = rvalid && !m_in_range;
            m_dec = rvalid && m_rr && rlast && m_in_range && (m_in_range ? m_cnt[rid] > 0 : 1'b0);
            if (m_dec) m_cnt[rid]--;
            if (m_busy) begin
                if (arready) m_busy = 1'b0;
            end else if (mg >= 0) begin
                m_cnt[mg]++;
                m_ar.id    = 4'(mg);
                m_ar.addr  = req_araddr[32*mg +: 32];
                m_ar.len   = req_arlen[4*mg +: 4];
                m_ar.size  = req_arsize[3*mg +: 3];
                m_ar.burst = req_arburst[2*mg +: 2];
                exp_q.push_back(m_ar);
                m_ptr  = (mg + 1) % N_REQ;
                m_busy = 1'b1;
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        req_arvalid = '0;
        req_araddr  = '0;
        req_arlen   = '0;
        req_arsize  = '0;
        req_arburst = '0;
        arready     = 1'b0;
        rid         = '0;
        rlast       = 1'b0;
        rvalid      = 1'b0;
        req_rready  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arvalid", 64'(arvalid_o), 64'(0));
        check("rst_payload", 64'({arid_o, araddr_o, arlen_o, arsize_o, arburst_o}), 64'(0));
        check("rst_id_err", 64'(id_err_o), 64'(0));
        check("rst_arready", 64'(req_arready_o), 64'(0));
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // single request from requester 0
        set_req(0, 32'h1000, 4'd3, 3'd2, 2'd1);
        set_req(1, 32'h2000, 4'd7, 3'd3, 2'd1);
        req_arvalid = 2'b01;
        #3;
        check("single_accept", 64'(req_arready_o), 64'(2'b01));
        tick();
        req_arvalid = '0;
        check("single_arvalid", 64'(arvalid_o), 64'(1));
        check("single_arid", 64'(arid_o), 64'(0));
        check("single_araddr", 64'(araddr_o), 64'(32'h1000));
        check("single_arlen", 64'(arlen_o), 64'(3));
        drain();

        // both held valid: alternating grants (fixed priority: requester 0 only)
        req_arvalid = 2'b11;
        arready     = 1'b1;
        repeat (8) tick();
        drain();

        // AR stalled five cycles in BUSY
        arready     = 1'b0;
        req_arvalid = 2'b01;
        tick();
        req_arvalid = 2'b10;
        repeat (5) tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        tick();
        req_arvalid = '0;
        arready     = 1'b1;
        tick();
        drain();

        // requester 1 exhausts its outstanding credit, requester 0 still served
        arready     = 1'b1;
        req_arvalid = 2'b10;
        repeat (10) tick();
        req_arvalid = 2'b11;
        repeat (6) tick();
        req_arvalid = 2'b10;
        tick();
        tick();
        rbeat(1, 1'b1, 2'b10);
        repeat (3) tick();
        drain();

        // R routing and back-pressure on requester 1
        req_arvalid = 2'b10;
        tick();
        req_arvalid = '0;
        tick();
        rbeat(1, 1'b0, 2'b10);
        rbeat(1, 1'b0, 2'b10);
        rbeat(1, 1'b1, 2'b00);
        rbeat(1, 1'b1, 2'b10);

        // out-of-range ID is drained and flagged
        rid        = 4'd5;
        rlast      = 1'b1;
        rvalid     = 1'b1;
        req_rready = 2'b00;
        #1;
        check("rid5_rready", 64'(rready_o), 64'(1));
        check("rid5_route", 64'(req_rvalid_o), 64'(0));
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        check("rid5_err_pulse", 64'(id_err_o), 64'(1));
        tick();
        check("rid5_err_clear", 64'(id_err_o), 64'(0));

        // accept and last beat for the same requester in one cycle
        req_arvalid = 2'b10;
        arready     = 1'b1;
        repeat (4) tick();
        rbeat(1, 1'b1, 2'b10);
        req_arvalid = 2'b10;
        repeat (10) tick();
        drain();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            req_arvalid = N_REQ'($urandom_range(0, 3));
            set_req(0, $urandom, 4'($urandom), 3'($urandom), 2'($urandom));
            set_req(1, $urandom, 4'($urandom), 3'($urandom), 2'($urandom));
            arready    = 1'($urandom_range(0, 1));
            rvalid     = ($urandom_range(0, 2) != 0);
            rid        = ID_W'($urandom_range(0, 5));
            rlast      = 1'($urandom_range(0, 1));
            req_rready = N_REQ'($urandom_range(0, 3));
            tick();
        end
        rvalid = 1'b0;
        drain();

        // reset while BUSY
        arready     = 1'b0;
        req_arvalid = 2'b01;
        tick();
        req_arvalid = '0;
        check("busy_before_rst", 64'(arvalid_o), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_arvalid", 64'(arvalid_o), 64'(0));
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        arready     = 1'b1;
        req_arvalid = 2'b10;
        repeat (10) tick();
        req_arvalid = '0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
